// File: rtl/mean_pool_scheduler.sv
// Round-robin scheduler sharing one mean_pooling engine between NREQ requesters.
// Latency: grant edge to out_valid is size+2 edges with a compliant engine.
// Backpressure: holds the result in OUT until out_ready; no new grant until accepted.
// Optional MEAN_POOL_WATCHDOG_EN adds a sticky err output and an ACCUM timeout.
module mean_pool_scheduler #(
    parameter int IL   = 4,
    parameter int FL   = 16,
    parameter int size = 4,
    parameter int NREQ = 4,
    parameter int W    = IL + FL,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*size*W-1:0]   req_data,
    output logic [NREQ-1:0]          gnt,
    output logic                     pool_en,
    output logic                     pool_input_ready,
    output logic [size*W-1:0]        pool_im,
    input  logic [W-1:0]             pool_om,
    input  logic                     pool_done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_data,
    output logic [IDW-1:0]           out_id,
    output logic                     busy
`ifdef MEAN_POOL_WATCHDOG_EN
    ,
    output logic                     err
`endif
);

    localparam int CW = IDW + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ACCUM,
        CAPTURE,
        OUT
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [IDW-1:0]      rr_ptr;
    logic [IDW-1:0]      nxt_ptr;
    logic                win_vld;
    logic [IDW-1:0]      win_id;
    logic [size*W-1:0]   win_vec;
    logic                wd_abort;

    // First requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        logic [CW-1:0] cand;
        cand    = '0;
        win_vld = 1'b0;
        win_id  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_ptr} + CW'(i);
            if (cand >= CW'(NREQ)) begin
                cand = cand - CW'(NREQ);
            end
            if (!win_vld && req[cand[IDW-1:0]]) begin
                win_vld = 1'b1;
                win_id  = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        win_vec = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (win_id == IDW'(r)) begin
                win_vec = req_data[r*size*W +: size*W];
            end
        end
    end

    assign nxt_ptr = (out_id == IDW'(NREQ - 1)) ? '0 : out_id + 1'b1;

`ifdef MEAN_POOL_WATCHDOG_EN
    localparam int WDW = $clog2(size + 2) + 1;
    logic [WDW-1:0] wd_cnt;
`endif

    always_comb begin
        state_nxt        = state;
        pool_en          = 1'b0;
        pool_input_ready = 1'b0;
        wd_abort         = 1'b0;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                pool_en          = 1'b1;
                pool_input_ready = 1'b1;
                state_nxt        = ACCUM;
            end
            ACCUM: begin
                pool_en = 1'b1;
                if (pool_done) begin
                    state_nxt = CAPTURE;
                end
`ifdef MEAN_POOL_WATCHDOG_EN
                else if (wd_cnt == WDW'(size + 1)) begin
                    wd_abort  = 1'b1;
                    state_nxt = OUT;
                end
`endif
            end
            CAPTURE: begin
                state_nxt = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy      = (state != IDLE);
    assign out_valid = (state == OUT);
    assign gnt       = (state == LOAD) ? (NREQ'(1) << out_id) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            pool_im  <= '0;
            out_id   <= '0;
            out_data <= '0;
        end else begin
            state <= state_nxt;
            // pool_im only moves on a grant, so it is stable for the whole job.
            if (state == IDLE && win_vld) begin
                pool_im <= win_vec;
                out_id  <= win_id;
            end
            if (state == CAPTURE) begin
                out_data <= pool_om;
            end
            if (wd_abort) begin
                out_data <= '0;
            end
            if (state == OUT && out_ready) begin
                rr_ptr <= nxt_ptr;
            end
        end
    end

`ifdef MEAN_POOL_WATCHDOG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (state != ACCUM) begin
                wd_cnt <= '0;
            end else if (!pool_done) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_abort) begin
                err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mean_pool_scheduler.sv
// Bench for mean_pool_scheduler: transaction-level model plus directed literal checks,
// with a stand-in engine that produces done size ACCUM cycles after load.
module tb_mean_pool_scheduler;

    localparam int IL   = 4;
    localparam int FL   = 16;
    localparam int SIZE = 4;
    localparam int NREQ = 4;
    localparam int W    = IL + FL;
    localparam int IDW  = $clog2(NREQ);

    logic                   clk;
    logic                   rst;
    logic [NREQ-1:0]        req;
    logic [NREQ*SIZE*W-1:0] req_data;
    logic [NREQ-1:0]        gnt;
    logic                   pool_en;
    logic                   pool_input_ready;
    logic [SIZE*W-1:0]      pool_im;
    logic [W-1:0]           pool_om;
    logic                   pool_done;
    logic                   out_valid;
    logic                   out_ready;
    logic [W-1:0]           out_data;
    logic [IDW-1:0]         out_id;
    logic                   busy;
`ifdef MEAN_POOL_WATCHDOG_EN
    logic                   err;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic hang = 1'b0;

    mean_pool_scheduler #(.IL(IL), .FL(FL), .size(SIZE), .NREQ(NREQ)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_data(req_data),
        .gnt(gnt),
        .pool_en(pool_en),
        .pool_input_ready(pool_input_ready),
        .pool_im(pool_im),
        .pool_om(pool_om),
        .pool_done(pool_done),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_id(out_id),
        .busy(busy)
`ifdef MEAN_POOL_WATCHDOG_EN
        ,
        .err(err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] vec_mean(input logic [SIZE*W-1:0] v);
        longint s;
        s = 0;
        for (int e = 0; e < SIZE; e++) s += longint'(v[e*W +: W]);
        return W'(s / SIZE);
    endfunction

    // Stand-in engine: clears/loads on en&input_ready, asserts done on its size-th ACCUM cycle.
    logic       eng_run;
    int         eng_cnt;
    logic [W-1:0] eng_om;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_run <= 1'b0;
            eng_cnt <= 0;
            eng_om  <= '0;
        end else if (pool_en && pool_input_ready) begin
            eng_run <= 1'b1;
            eng_cnt <= 0;
            eng_om  <= vec_mean(pool_im);
        end else if (pool_en && eng_run) begin
            eng_cnt <= eng_cnt + 1;
        end else if (!pool_en) begin
            eng_run <= 1'b0;
        end
    end
    assign pool_done = eng_run && pool_en && !pool_input_ready && (eng_cnt == SIZE - 1) && !hang;
    assign pool_om   = eng_om;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Transaction model: one job at a time, timestamped from its grant edge.
    bit                m_act  = 0;
    bit                m_hang = 0;
    bit                m_err  = 0;
    int                m_ptr  = 0;
    int                m_id   = 0;
    int                m_t0   = 0;
    int                m_vt   = 0;
    logic [W-1:0]      m_data = '0;
    logic [SIZE*W-1:0] m_im   = '0;

    task automatic model_step();
        logic [NREQ-1:0] e_gnt;
        bit e_valid;
        bit found;
        int c;
        if (rst) begin
            m_act = 0; m_ptr = 0; m_im = '0; m_err = 0;
        end
        if (m_act && m_hang && cyc >= m_vt) m_err = 1;
        e_gnt = '0;
        if (m_act && cyc == m_t0) e_gnt[m_id] = 1'b1;
        e_valid = m_act && (cyc >= m_vt);
        check("gnt", gnt, e_gnt);
        check("pool_input_ready", pool_input_ready, m_act && cyc == m_t0);
        check("pool_en", pool_en, m_act && cyc >= m_t0 && cyc < (m_hang ? m_vt : m_vt - 1));
        check("out_valid", out_valid, e_valid);
        check("busy", busy, m_act);
        check("pool_im", pool_im, m_im);
        if (e_valid) begin
            check("out_data", out_data, m_data);
            check("out_id", out_id, m_id);
        end
`ifdef MEAN_POOL_WATCHDOG_EN
        check("err", err, m_err);
`endif
        if (!rst) begin
            if (e_valid && out_ready) begin
                m_act = 0;
                m_ptr = (m_id + 1) % NREQ;
            end else if (!m_act && req != '0) begin
                found = 0;
                for (int k = 0; k < NREQ; k++) begin
                    c = (m_ptr + k) % NREQ;
                    if (!found && req[c]) begin
                        found = 1;
                        m_id  = c;
                    end
                end
                m_act  = 1;
                m_t0   = cyc + 1;
                m_hang = hang;
                m_vt   = m_t0 + SIZE + 2 + (hang ? 1 : 0);
                m_im   = req_data[m_id*SIZE*W +: SIZE*W];
                m_data = hang ? '0 : vec_mean(m_im);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_valid(input string nm, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check(nm, out_valid, 1'b1);
    endtask

    task automatic set_vec(input int r, input logic [W-1:0] e0, input logic [W-1:0] e1,
                           input logic [W-1:0] e2, input logic [W-1:0] e3);
        req_data[(r*SIZE+0)*W +: W] = e0;
        req_data[(r*SIZE+1)*W +: W] = e1;
        req_data[(r*SIZE+2)*W +: W] = e2;
        req_data[(r*SIZE+3)*W +: W] = e3;
    endtask

    int e0;
    int ids[5];
    logic [IDW-1:0] exp_ids[5];

    initial begin
        rst = 1'b0; req = '0; req_data = '0; out_ready = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("reset_gnt", gnt, '0);
        check("reset_busy", busy, 1'b0);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_pool_en", pool_en, 1'b0);
        check("reset_pool_im", pool_im, '0);
        tick();
        tick();
        rst = 1'b0;

        // Single request from requester 0: mean of 4,8,2,2 is 4.0
        tick();
        set_vec(0, 20'h40000, 20'h80000, 20'h20000, 20'h20000);
        req = 4'b0001;
        e0 = cyc + 1;
        tick();
        check("single_gnt", gnt, 4'b0001);
        req = '0;
        wait_valid("single_valid", 20);
        check("single_latency", cyc - e0, 6);
        check("single_data", out_data, 20'h40000);
        check("single_id", out_id, 0);
        tick();

        // All four requesting continuously: strict rotation 0,1,2,3,0
        do_reset();
        tick();
        set_vec(0, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF);
        set_vec(1, 20'h00001, 20'h00002, 20'h00003, 20'h00003);
        set_vec(2, 20'h18000, 20'h28000, 20'h04000, 20'h0C000);
        set_vec(3, 20'h40000, 20'h80000, 20'h20000, 20'h20000);
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_valid("rr_valid", 20);
            ids[j] = int'(out_id);
            if (j == 0) check("rr_first_data", out_data, 20'hFFFFF);
            if (j == 1) check("rr_trunc_data", out_data, 20'h00002);
            tick();
        end
        req = '0;
        exp_ids[0] = 0; exp_ids[1] = 1; exp_ids[2] = 2; exp_ids[3] = 3; exp_ids[4] = 0;
        for (int j = 0; j < 5; j++) check("rr_order", ids[j], exp_ids[j]);
        repeat (3) tick();

        // Backpressure: result held for 10 cycles with out_ready low
        do_reset();
        tick();
        out_ready = 1'b0;
        req = 4'b0100;
        tick();
        req = '0;
        wait_valid("bp_valid", 20);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            check("bp_hold_valid", out_valid, 1'b1);
            check("bp_hold_data", out_data, 20'h14000);
            check("bp_hold_id", out_id, 2);
            check("bp_no_gnt", gnt, '0);
        end
        tick();
        out_ready = 1'b1;
        tick();
        check("bp_released", out_valid, 1'b0);
        check("bp_idle", busy, 1'b0);

        // Asynchronous reset in the middle of ACCUM
        do_reset();
        tick();
        req = 4'b0001;
        tick();
        req = '0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rst_gnt", gnt, '0);
        check("rst_pool_en", pool_en, 1'b0);
        check("rst_input_ready", pool_input_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_pool_im", pool_im, '0);
        check("rst_out_data", out_data, '0);
        check("rst_out_id", out_id, '0);
        tick();
        tick();
        rst = 1'b0;
        req = 4'b0010;
        tick();
        check("post_rst_gnt", gnt, 4'b0010);
        req = '0;
        wait_valid("post_rst_valid", 20);
        check("post_rst_id", out_id, 1);
        tick();

        // req_data of the winner changes right after the grant
        do_reset();
        tick();
        req = 4'b1000;
        tick();
        set_vec(3, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF);
        req = '0;
        wait_valid("latch_valid", 20);
        check("latch_data", out_data, 20'h40000);
        check("latch_id", out_id, 3);
        tick();

`ifdef MEAN_POOL_WATCHDOG_EN
        // Hung engine: abort after size+2 ACCUM cycles, sticky err
        do_reset();
        tick();
        hang = 1'b1;
        req = 4'b0001;
        e0 = cyc + 1;
        tick();
        req = '0;
        wait_valid("wd_valid", 30);
        check("wd_latency", cyc - e0, SIZE + 3);
        check("wd_data", out_data, '0);
        check("wd_err", err, 1'b1);
        tick();
        hang = 1'b0;
        req = 4'b0010;
        tick();
        req = '0;
        wait_valid("wd_next_valid", 20);
        check("wd_err_sticky", err, 1'b1);
        tick();
        do_reset();
        check("wd_err_cleared", err, 1'b0);
`endif

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mean_pool_scheduler.md
Name: mean_pool_scheduler

Overview:
- Shares one mean_pooling engine between NREQ requesters, e.g. attention heads that each need a pooled vector.
- Arbitrates round-robin, latches the winner's size-element vector, and drives the engine's en/input_ready sequence.
- Waits for the engine's done, captures om, and returns the result tagged with the requester id over a valid/ready handshake.
- Sits between the requester lanes and a single mean_pooling instance in the top-level datapath.

Parameters:
- IL, 4, integer bits of the fixed-point word
- FL, 16, fractional bits of the fixed-point word
- size, 4, elements per pooled vector; must be a power of two, at least 2
- NREQ, 4, number of requesters; must be at least 2
- W, IL+FL, word width (derived)
- IDW, $clog2(NREQ), requester id width (derived)

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous reset, active-high
- req  in  NREQ  per-requester request, level; held until that requester's gnt bit
- req_data  in  NREQ*size*W  flattened vectors; requester r, element e at bits [(r*size+e)*W +: W]
- gnt  out  NREQ  one-hot grant, one-cycle pulse
- pool_en  out  1  to engine en
- pool_input_ready  out  1  to engine input_ready (clear/load)
- pool_im  out  size*W  latched vector to engine im; element e at [e*W +: W]
- pool_om  in  W  engine result
- pool_done  in  1  engine done
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  W  pooled mean
- out_id  out  IDW  id of the requester that owns out_data
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=IDLE, rr_ptr=0.
  - gnt, pool_en, pool_input_ready, out_valid, busy all 0.
  - pool_im, out_data, out_id all 0.
  - Any in-flight job is dropped with no output.
- FSM states: IDLE, LOAD, ACCUM, CAPTURE, OUT.
- IDLE:
  - If req is nonzero at an edge (call it E0), pick the first requester with req set, searching from rr_ptr upward and wrapping.
  - At E0: pulse the winner's gnt bit for one cycle, latch its vector into pool_im, set out_id to the winner, go to LOAD.
  - If req is zero, stay in IDLE.
- LOAD (1 cycle): pool_en=1, pool_input_ready=1. Next edge (E1) goes to ACCUM.
- ACCUM: pool_en=1, pool_input_ready=0. Stay until an edge samples pool_done=1, then go to CAPTURE. With a compliant engine this edge is E1+size.
- CAPTURE (1 cycle): pool_en=0. At the next edge, out_data <= pool_om, out_valid <= 1, go to OUT.
- OUT:
  - Hold out_data, out_id and out_valid=1 until out_ready=1 at an edge.
  - At that edge: out_valid <= 0, rr_ptr <= out_id+1 (wrapping modulo NREQ), go to IDLE.
- Latency: out_valid rises at edge E0+size+2 when out_ready is already high (6 edges for size=4).
- Throughput: one job per size+4 cycles at best. The next grant can occur at the edge after the accepting edge, never on the same edge.
- Data stability:
  - pool_im changes only at grant edges, so it is stable from LOAD through OUT.
  - req_data changes after the grant do not affect the job.
  - Dropping req after the grant does not cancel the job.
- Simultaneous requests: strictly round-robin. A requester cannot win twice while another requester is continuously requesting.
- pool_done outside ACCUM is ignored.
- out_ready outside OUT is ignored.
- The result is an unsigned W-bit truncated mean, as produced by the engine. The scheduler does no arithmetic on it.

Optional Feature:
- Macro: MEAN_POOL_WATCHDOG_EN.
- When defined:
  - Add output err (1 bit, reset 0).
  - An ACCUM cycle counter aborts the job if pool_done has not been seen after size+2 ACCUM cycles.
  - On abort: go to OUT with out_data=0 and err=1 (err is sticky until rst). The handshake completes normally.
- When undefined:
  - No err port, no counter.
  - The FSM waits in ACCUM indefinitely.

Test Plan:
- Single request: size=4, req=0001, vector {4.0,8.0,2.0,2.0} (0x40000, 0x80000, 0x20000, 0x20000), out_ready=1 -> gnt=0001 for one cycle; out_valid at E0+6 with out_data=0x40000 (4.0), out_id=0.
- All four requesting: req=1111, out_ready=1 -> grant order 0,1,2,3,0; each out_id matches its grant; no two gnt bits high at once.
- Backpressure: out_ready=0 for 10 cycles in OUT -> out_valid, out_data and out_id stable; no new gnt; the job completes one edge after out_ready=1.
- Reset mid-ACCUM: assert rst two cycles after LOAD -> all outputs 0 immediately (async); after release with req=0010, the grant goes to 1 with rr_ptr=0 search.
- req_data change after grant: modify the winner's vector at E0+1 -> result still reflects the vector latched at E0.
- With MEAN_POOL_WATCHDOG_EN defined: hold pool_done=0 -> after size+2 ACCUM cycles, out_valid=1, out_data=0, err=1; err stays 1 through later good jobs until rst.
